if_stage_frontend: RTL and testbench

IF_STAGE_FRONTEND -- requirements
Module: if_stage_frontend

---
 rtl/riscv_pkg.sv | 6 +
 rtl/fetch_buffer.sv | 95 +++++++++
 rtl/if_stage_frontend.sv | 125 ++++++++++++
 tb/tb_if_stage_frontend.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 constants for the fetch front end.
package riscv_pkg;
  localparam int          XLEN      = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0
endpackage

// File: rtl/fetch_buffer.sv
// In-order fetch buffer: entries are allocated at request time and filled
// in order as responses arrive; only a filled head can be popped.
module fetch_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            push,
  input  logic [XLEN-1:0] push_pc,
  input  logic            fill,
  input  logic [31:0]     fill_data,
  input  logic            pop,
  output logic            head_vld,
  output logic [XLEN-1:0] head_pc,
  output logic [31:0]     head_instr,
  output logic [CW-1:0]   alloc_cnt,
  output logic [CW-1:0]   unfilled_cnt
);
  logic [DEPTH-1:0]            vld_q, vld_d, filled_q, filled_d;
  logic [DEPTH-1:0][XLEN-1:0]  pc_q, pc_d;
  logic [DEPTH-1:0][31:0]      instr_q, instr_d;
  logic [PW-1:0]               head_q, head_d, tail_q, tail_d, fptr_q, fptr_d;

  assign head_vld   = vld_q[head_q] & filled_q[head_q];
  assign head_pc    = pc_q[head_q];
  assign head_instr = instr_q[head_q];

  always_comb begin
    alloc_cnt    = '0;
    unfilled_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      alloc_cnt    = alloc_cnt + CW'(vld_q[i]);
      unfilled_cnt = unfilled_cnt + CW'(vld_q[i] & ~filled_q[i]);
    end
  end

  // fill/pop/push always touch distinct entries: fill needs an unfilled
  // valid slot, pop a filled one, push an empty one.
  always_comb begin
    vld_d    = vld_q;
    filled_d = filled_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    head_d   = head_q;
    tail_d   = tail_q;
    fptr_d   = fptr_q;
    if (fill && vld_q[fptr_q] && !filled_q[fptr_q]) begin
      filled_d[fptr_q] = 1'b1;
      instr_d[fptr_q]  = fill_data;
      fptr_d           = fptr_q + PW'(1);
    end
    if (pop && head_vld) begin
      vld_d[head_q]    = 1'b0;
      filled_d[head_q] = 1'b0;
      head_d           = head_q + PW'(1);
    end
    if (push && !vld_q[tail_q]) begin
      vld_d[tail_q]    = 1'b1;
      filled_d[tail_q] = 1'b0;
      pc_d[tail_q]     = push_pc;
      tail_d           = tail_q + PW'(1);
    end
    if (flush) begin
      vld_d    = '0;
      filled_d = '0;
      head_d   = '0;
      tail_d   = '0;
      fptr_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= '0;
      filled_q <= '0;
      pc_q     <= '0;
      instr_q  <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      fptr_q   <= '0;
    end else begin
      vld_q    <= vld_d;
      filled_q <= filled_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      fptr_q   <= fptr_d;
    end
  end
endmodule

// File: rtl/if_stage_frontend.sv
// Instruction-fetch front end: PC generation, request throttling, stale
// response dropping after redirects, and the IF/ID pipeline register.
module if_stage_frontend
  import riscv_pkg::*;
#(
  parameter int              XLEN      = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(riscv_pkg::RESET_PC),
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Stall_F,
  input  logic            Stall_D,
  input  logic            Flush_D,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  output logic            FetchStall
);
  localparam int            CW      = $clog2(BUF_DEPTH + 1);
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(BUF_DEPTH);

  logic [XLEN-1:0] pcf_q, pcf_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pcd_q, pcd_d, pc4d_q, pc4d_d;
  logic            vldd_q, vldd_d;

  logic            head_vld;
  logic [XLEN-1:0] head_pc;
  logic [31:0]     head_instr;
  logic [CW-1:0]   alloc_cnt, unfilled_cnt;
  logic            req_fire, fill, pop;

  // Requests pending drop still occupy memory-side slots, so they count
  // against the outstanding limit.
  assign imem_req_valid = !Stall_F && !PCSrcE &&
                          (({1'b0, alloc_cnt} + {1'b0, drop_cnt_q}) < DEPTH_W);
  assign imem_addr      = pcf_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign fill           = imem_rsp_valid && (drop_cnt_q == '0) && !PCSrcE;
  assign pop            = !Flush_D && !Stall_D && head_vld;
  assign FetchStall     = !Flush_D && !Stall_D && !head_vld;

  fetch_buffer #(.XLEN(XLEN), .DEPTH(BUF_DEPTH)) u_fbuf (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (PCSrcE),
    .push         (req_fire),
    .push_pc      (pcf_q),
    .fill         (fill),
    .fill_data    (imem_rsp_data),
    .pop          (pop),
    .head_vld     (head_vld),
    .head_pc      (head_pc),
    .head_instr   (head_instr),
    .alloc_cnt    (alloc_cnt),
    .unfilled_cnt (unfilled_cnt)
  );

  always_comb begin
    pcf_d      = pcf_q;
    drop_cnt_d = drop_cnt_q;
    if (req_fire) pcf_d = pcf_q + XLEN'(4);
    if (PCSrcE) pcf_d = PCTargetE;
    // A response landing in the redirect cycle belongs to an unfilled entry
    // or to the drop count; either way it is already consumed here.
    if (PCSrcE)
      drop_cnt_d = drop_cnt_q + unfilled_cnt - CW'(imem_rsp_valid);
    else if (imem_rsp_valid && drop_cnt_q != '0)
      drop_cnt_d = drop_cnt_q - CW'(1);
  end

  always_comb begin
    instr_d = instr_q;
    pcd_d   = pcd_q;
    pc4d_d  = pc4d_q;
    vldd_d  = vldd_q;
    if (Flush_D) begin
      instr_d = NOP_INSTR;
      vldd_d  = 1'b0;
    end else if (Stall_D) begin
      vldd_d  = vldd_q;
    end else if (head_vld) begin
      instr_d = head_instr;
      pcd_d   = head_pc;
      pc4d_d  = head_pc + XLEN'(4);
      vldd_d  = 1'b1;
    end else begin
      instr_d = NOP_INSTR;
      vldd_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcf_q      <= RESET_PC;
      drop_cnt_q <= '0;
      instr_q    <= NOP_INSTR;
      pcd_q      <= '0;
      pc4d_q     <= '0;
      vldd_q     <= 1'b0;
    end else begin
      pcf_q      <= pcf_d;
      drop_cnt_q <= drop_cnt_d;
      instr_q    <= instr_d;
      pcd_q      <= pcd_d;
      pc4d_q     <= pc4d_d;
      vldd_q     <= vldd_d;
    end
  end

  assign InstrD   = instr_q;
  assign PCD      = pcd_q;
  assign PCPlus4D = pc4d_q;
  assign ValidD   = vldd_q;
endmodule

// File: tb/tb_if_stage_frontend.sv
// Directed bench for if_stage_frontend with an in-order memory model that
// can withhold responses to build up outstanding requests.
module tb_if_stage_frontend;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Stall_F, Stall_D, Flush_D, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD, FetchStall;

  int n_chk = 0;
  int n_err = 0;
  bit mem_hold = 1'b0;
  logic [31:0] q_addr[$];

  if_stage_frontend dut (
    .clk(clk), .rst_n(rst_n),
    .Stall_F(Stall_F), .Stall_D(Stall_D), .Flush_D(Flush_D), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .FetchStall(FetchStall)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[29:0], 2'b11} ^ 32'h5A00_0000;
  endfunction

  // Responds one cycle after the handshake unless held; forgets everything on reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_addr.delete();
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= '0;
    end else begin
      if (imem_req_valid && imem_req_ready) q_addr.push_back(imem_addr);
      if (!mem_hold && q_addr.size() > 0) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= mem_word(q_addr.pop_front());
      end else begin
        imem_rsp_valid <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input logic [31:0] pc, input string tag);
    bit got = 1'b0;
    logic [31:0] p4;
    p4 = pc + 32'd4;
    for (int i = 0; i < 12 && !got; i++) begin
      tick();
      if (ValidD === 1'b1) got = 1'b1;
    end
    chk({tag, "_arrive"}, 64'(got), 64'd1);
    if (got) begin
      chk({tag, "_pcd"}, 64'(PCD), 64'(pc));
      chk({tag, "_instr"}, 64'(InstrD), 64'(mem_word(pc)));
      chk({tag, "_pc4"}, 64'(PCPlus4D), 64'(p4));
    end
  endtask

  initial begin
    rst_n = 1'b0; Stall_F = 1'b0; Stall_D = 1'b0; Flush_D = 1'b0; PCSrcE = 1'b0;
    PCTargetE = '0; imem_req_ready = 1'b1;
    #12;
    chk("rst_instr", 64'(InstrD), 64'(NOP));
    chk("rst_valid", 64'(ValidD), 64'd0);
    chk("rst_pcd", 64'(PCD), 64'd0);
    chk("rst_pc4", 64'(PCPlus4D), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'd0);
    rst_n = 1'b1;

    // Cold start: request, fill, then present.
    tick(); chk("cs1_valid", 64'(ValidD), 64'd0); chk("cs1_fstall", 64'(FetchStall), 64'd1);
    tick(); chk("cs2_valid", 64'(ValidD), 64'd0);
    tick(); chk("cs3_valid", 64'(ValidD), 64'd1); chk("cs3_pcd", 64'(PCD), 64'h0);
    chk("cs3_instr", 64'(InstrD), 64'(mem_word(32'h0)));
    tick(); chk("cs4_valid", 64'(ValidD), 64'd1); chk("cs4_pcd", 64'(PCD), 64'h4);
    wait_valid(32'h8, "seq8");

    // Decode stall with the buffer filling up behind it.
    Stall_D = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stl_valid", 64'(ValidD), 64'd1);
      chk("stl_pcd", 64'(PCD), 64'h8);
      chk("stl_reqv", 64'(imem_req_valid), 64'd0);
    end
    Stall_D = 1'b0;
    wait_valid(32'hC, "stl_c");
    wait_valid(32'h10, "stl_10");
    wait_valid(32'h14, "stl_14");

    // Flush wins over stall; head stays queued.
    Flush_D = 1'b1; Stall_D = 1'b1;
    tick();
    chk("fs_valid", 64'(ValidD), 64'd0);
    chk("fs_instr", 64'(InstrD), 64'(NOP));
    chk("fs_pcd", 64'(PCD), 64'h14);
    Flush_D = 1'b0; Stall_D = 1'b0;
    wait_valid(32'h18, "fs_18");

    // Redirect mid-stream to the top of the address space; PC wraps.
    PCSrcE = 1'b1; Flush_D = 1'b1; PCTargetE = 32'hFFFF_FFFC;
    #1 chk("rd_reqv", 64'(imem_req_valid), 64'd0);
    tick();
    PCSrcE = 1'b0; Flush_D = 1'b0;
    chk("rd_valid", 64'(ValidD), 64'd0);
    wait_valid(32'hFFFF_FFFC, "wrap_top");
    wait_valid(32'h0, "wrap_0");

    // Redirect with two unfilled requests outstanding.
    mem_hold = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("hold_reqv", 64'(imem_req_valid), 64'd0);
    PCSrcE = 1'b1; Flush_D = 1'b1; PCTargetE = 32'h100;
    tick();
    PCSrcE = 1'b0; Flush_D = 1'b0;
    chk("drop_reqv", 64'(imem_req_valid), 64'd0);
    mem_hold = 1'b0;
    wait_valid(32'h100, "rd_100");
    wait_valid(32'h104, "rd_104");

    // Asynchronous reset with two requests in flight.
    mem_hold = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(ValidD), 64'd0);
    chk("ar_instr", 64'(InstrD), 64'(NOP));
    chk("ar_pcd", 64'(PCD), 64'd0);
    chk("ar_pc4", 64'(PCPlus4D), 64'd0);
    chk("ar_addr", 64'(imem_addr), 64'd0);
    mem_hold = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_valid(32'h0, "ar_0");
    wait_valid(32'h4, "ar_4");

    // Memory not ready: buffer drains, PC holds at 0xC.
    imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("nr_addr", 64'(imem_addr), 64'hC);
      if (i >= 2) begin
        chk("nr_fstall", 64'(FetchStall), 64'd1);
        chk("nr_instr", 64'(InstrD), 64'(NOP));
        chk("nr_valid", 64'(ValidD), 64'd0);
      end
    end
    imem_req_ready = 1'b1;
    wait_valid(32'hC, "nr_c");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
